mem_bank_ctrl: RTL

Memory-side controller of the memory tile, directly downstream of the OBI atomics resolver. Accepts OBI subordinate requests, decodes them onto a row-banked array of single-port, 1-cycle-latency SRAM macros, and returns OBI responses through a credit-managed response FIFO. Unlike a fixed-grant shim, it honours r_ready backpressure and never drops read data.

---
 rtl/mem_bank_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// mem_bank_ctrl : OBI subordinate onto row-banked 1-cycle SRAM macros, with a
//                 credit-managed fall-through response FIFO.
// Revision      : 1.0
// ============================================================================
module mem_bank_ctrl #(
  parameter int AddrWidth    = 48,
  parameter int DataWidth    = 512,
  parameter int IdWidth      = 4,
  parameter int SramNumWords = 512,
  parameter int NumBankRows  = 4,
  parameter int RspFifoDepth = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                a_req_i,
  output logic                                a_gnt_o,
  input  logic [AddrWidth-1:0]                a_addr_i,
  input  logic                                a_we_i,
  input  logic [DataWidth/8-1:0]              a_be_i,
  input  logic [DataWidth-1:0]                a_wdata_i,
  input  logic [IdWidth-1:0]                  a_aid_i,
  output logic                                r_valid_o,
  input  logic                                r_ready_i,
  output logic [DataWidth-1:0]                r_rdata_o,
  output logic [IdWidth-1:0]                  r_rid_o,
  output logic                                r_err_o,
  output logic [NumBankRows-1:0]              sram_req_o,
  output logic                                sram_we_o,
  output logic [$clog2(SramNumWords)-1:0]     sram_addr_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  output logic [DataWidth/8-1:0]              sram_be_o,
  input  logic [NumBankRows*DataWidth-1:0]    sram_rdata_i
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int OffBits  = $clog2(BeWidth);
  localparam int WordBits = $clog2(SramNumWords);
  localparam int RowBits  = $clog2(NumBankRows);
  localparam int TopBit   = OffBits + WordBits + RowBits;
  localparam int CntW     = $clog2(RspFifoDepth + 1);
  localparam int PtrW     = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;

  // ---------------------------------------------------------------- decode
  logic [RowBits-1:0] req_row;
  logic               out_of_range;
  logic               handshake;
  logic [CntW:0]      credits_used;
  logic [CntW-1:0]    count;
  logic               inflight;
  logic               unused_addr_bits;

  assign req_row          = a_addr_i[OffBits+WordBits +: RowBits];
  assign out_of_range     = |a_addr_i[AddrWidth-1:TopBit];
  assign unused_addr_bits = ^a_addr_i[OffBits-1:0];

  // Grant looks only at registered occupancy, so a pop frees its credit next cycle.
  assign credits_used = {1'b0, count} + {{CntW{1'b0}}, inflight};
  assign a_gnt_o      = a_req_i & ~rst_i & (credits_used < (CntW+1)'(RspFifoDepth));
  assign handshake    = a_gnt_o;

  assign sram_req_o   = (handshake & ~out_of_range)
                      ? ({{(NumBankRows-1){1'b0}}, 1'b1} << req_row) : '0;
  assign sram_we_o    = a_we_i;
  assign sram_addr_o  = a_addr_i[OffBits +: WordBits];
  assign sram_wdata_o = a_wdata_i;
  assign sram_be_o    = a_be_i;

  // ------------------------------------------------------- pipeline stage
  logic [IdWidth-1:0] aid_q;
  logic               we_q;
  logic               err_q;
  logic [RowBits-1:0] row_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      aid_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      row_q    <= '0;
    end else begin
      inflight <= handshake;
      if (handshake) begin
        aid_q <= a_aid_i;
        we_q  <= a_we_i;
        err_q <= out_of_range;
        row_q <= req_row;
      end
    end
  end

  logic [DataWidth-1:0] row_rdata [NumBankRows];

  for (genvar g = 0; g < NumBankRows; g++) begin : g_row_rdata
    assign row_rdata[g] = sram_rdata_i[g*DataWidth +: DataWidth];
  end

  logic                 push;
  logic [DataWidth-1:0] push_rdata;

  assign push       = inflight;
  assign push_rdata = (we_q | err_q) ? '0 : row_rdata[row_q];

  // ---------------------------------------------------- response FIFO
  logic [DataWidth-1:0] fifo_rdata [RspFifoDepth];
  logic [IdWidth-1:0]   fifo_rid   [RspFifoDepth];
  logic                 fifo_err   [RspFifoDepth];
  logic [PtrW-1:0]      wptr;
  logic [PtrW-1:0]      rptr;
  logic                 fifo_empty;
  logic                 bypass;
  logic                 do_write;
  logic                 do_read;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty = (count == '0);
  // An empty FIFO hands a fresh response straight to the output; it is only
  // stored if that same cycle does not consume it.
  assign bypass     = push & fifo_empty & r_ready_i;
  assign do_write   = push & ~bypass;
  assign do_read    = r_ready_i & ~fifo_empty;

  assign r_valid_o  = ~fifo_empty | push;

  always_comb begin
    r_rdata_o = '0;
    r_rid_o   = '0;
    r_err_o   = 1'b0;
    if (!fifo_empty) begin
      r_rdata_o = fifo_rdata[rptr];
      r_rid_o   = fifo_rid[rptr];
      r_err_o   = fifo_err[rptr];
    end else if (push) begin
      r_rdata_o = push_rdata;
      r_rid_o   = aid_q;
      r_err_o   = err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (do_write) wptr <= ptr_inc(wptr);
      if (do_read)  rptr <= ptr_inc(rptr);
      case ({do_write, do_read})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      fifo_rdata[wptr] <= push_rdata;
      fifo_rid[wptr]   <= aid_q;
      fifo_err[wptr]   <= err_q;
    end
  end

`ifndef SYNTHESIS
  a_sram_req_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(sram_req_o));
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    do_write |-> (count < CntW'(RspFifoDepth)));
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_valid_o & r_ready_i) |-> (!fifo_empty || push));
`endif

endmodule
`default_nettype wire
